// File: rtl/stopwatch_bcd_counter.sv
// rtl/stopwatch_bcd_counter.sv - tenth-of-a-second time base and M:SS.t BCD counter with run/pause/clear.
// Optional lap freeze of the digit outputs is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] Minutes,
    output logic [3:0] Tens_Seconds,
    output logic [3:0] Ones_Seconds,
    output logic [3:0] Tenths_Seconds,
    output logic       running,
    output logic       rollover
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          tick;

    logic [3:0] min_q,  tens_q,  ones_q,  tth_q;
    logic [3:0] min_n,  tens_n,  ones_n,  tth_n;
    logic       c_tth,  c_ones,  c_tens,  c_min;
    logic       wrap;

    always_comb begin
        tick = (state == RUN) && (presc == PRESC_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear dominates start_stop; a tick on the pausing edge is still applied below
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSED;
                PAUSED:  state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && state != RUN && state != PAUSED) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        presc_next = presc;
        if (clear) begin
            presc_next = '0;
        end else if (state == RUN) begin
            presc_next = tick ? '0 : presc + 1'b1;
        end
    end

    // carries ripple through all four digits in the tick cycle; >= keeps the chain self-correcting
    always_comb begin
        c_tth  = (tth_q >= 4'd9);
        c_ones = c_tth && (ones_q >= 4'd9);
        c_tens = c_ones && (tens_q >= 4'd5);
        c_min  = c_tens && (min_q >= 4'd9);
        tth_n  = tth_q;
        ones_n = ones_q;
        tens_n = tens_q;
        min_n  = min_q;
        wrap   = 1'b0;
        if (clear) begin
            tth_n  = 4'd0;
            ones_n = 4'd0;
            tens_n = 4'd0;
            min_n  = 4'd0;
        end else if (tick) begin
            tth_n = c_tth ? 4'd0 : tth_q + 4'd1;
            if (c_tth) begin
                ones_n = c_ones ? 4'd0 : ones_q + 4'd1;
            end
            if (c_ones) begin
                tens_n = c_tens ? 4'd0 : tens_q + 4'd1;
            end
            if (c_tens) begin
                min_n = c_min ? 4'd0 : min_q + 4'd1;
            end
            wrap = c_min;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            tth_q    <= 4'd0;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            min_q    <= 4'd0;
            running  <= 1'b0;
            rollover <= 1'b0;
        end else begin
            presc    <= presc_next;
            tth_q    <= tth_n;
            ones_q   <= ones_n;
            tens_q   <= tens_n;
            min_q    <= min_n;
            running  <= (state_next == RUN);
            rollover <= wrap;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       freeze;
    logic       freeze_next;
    logic [3:0] disp_min, disp_tens, disp_ones, disp_tth;

    always_comb begin
        freeze_next = freeze;
        if (clear) begin
            freeze_next = 1'b0;
        end else if (lap) begin
            freeze_next = ~freeze;
        end
    end

    // the freezing edge captures the count written on that same edge, then holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze    <= 1'b0;
            disp_min  <= 4'd0;
            disp_tens <= 4'd0;
            disp_ones <= 4'd0;
            disp_tth  <= 4'd0;
        end else begin
            freeze <= freeze_next;
            if (!(freeze && freeze_next)) begin
                disp_min  <= min_n;
                disp_tens <= tens_n;
                disp_ones <= ones_n;
                disp_tth  <= tth_n;
            end
        end
    end

    assign Minutes        = disp_min;
    assign Tens_Seconds   = disp_tens;
    assign Ones_Seconds   = disp_ones;
    assign Tenths_Seconds = disp_tth;
`else
    logic lap_unused;
    assign lap_unused     = lap;
    assign Minutes        = min_q;
    assign Tens_Seconds   = tens_q;
    assign Ones_Seconds   = ones_q;
    assign Tenths_Seconds = tth_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb/tb_stopwatch_bcd_counter.sv - randomized self-checking bench against an elapsed-tenths model.
module tb_stopwatch_bcd_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
    logic       running, rollover;
    logic [15:0] dut_digits;

    int n_cmp = 0;
    int n_fail = 0;

    // model: 0 idle, 1 run, 2 paused; time kept as total elapsed tenths
    int m_mode = 0;
    int m_phase = 0;
    int m_total = 0;
    bit m_roll = 1'b0;

    stopwatch_bcd_counter #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_stop(start_stop),
        .clear(clear),
        .lap(lap),
        .Minutes(Minutes),
        .Tens_Seconds(Tens_Seconds),
        .Ones_Seconds(Ones_Seconds),
        .Tenths_Seconds(Tenths_Seconds),
        .running(running),
        .rollover(rollover)
    );

    assign dut_digits = {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_digits();
        int t;
        t = m_total;
        return {4'(t / 600), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    function automatic bit exp_running();
        return (m_mode == 1);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_phase = 0;
        m_total = 0;
        m_roll = 1'b0;
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp);
        @(negedge clk);
        start_stop = ss;
        clear = clr;
        lap = lp;
        @(posedge clk);
        m_roll = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            if (m_mode == 1) begin
                m_phase = m_phase + 1;
                if (m_phase == TD) begin
                    m_phase = 0;
                    m_total = (m_total + 1) % 6000;
                    m_roll = (m_total == 0);
                end
            end
            if (ss) m_mode = (m_mode == 1) ? 2 : 1;
        end
        #1;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_digits: got %h, expected %h", dut_digits, 16'h0000);
        end
        n_cmp++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_running: got %b, expected 0", running);
        end
        n_cmp++;
        if (rollover !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rollover: got %b, expected 0", rollover);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1 || dut_digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL run_start: got running=%b digits=%h, expected running=1 digits=0000", running, dut_digits);
        end
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_digits !== exp_digits()) begin
                n_fail++;
                $display("FAIL run_cycle%0d: got %h, expected %h", i, dut_digits, exp_digits());
            end
            if (i == 3 || i == 4 || i == 36 || i == 40) begin
                n_cmp++;
                if (dut_digits !== ((i == 3) ? 16'h0000 : (i == 4) ? 16'h0001 : (i == 36) ? 16'h0009 : 16'h0010)) begin
                    n_fail++;
                    $display("FAIL run_edge_E+%0d: got %h", i, dut_digits);
                end
            end
        end
    endtask

    task automatic test_carry();
        int n;
        n = 0;
        while (m_total != 599 && n < 30000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            n_cmp++;
            if (dut_digits !== exp_digits() || running !== 1'b1) begin
                n_fail++;
                $display("FAIL carry_track: got %h run=%b, expected %h run=1", dut_digits, running, exp_digits());
            end
        end
        n_cmp++;
        if (dut_digits !== 16'h0599) begin
            n_fail++;
            $display("FAIL carry_0599: got %h, expected 0599", dut_digits);
        end
        repeat (TD) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_digits !== 16'h1000) begin
            n_fail++;
            $display("FAIL carry_1000: got %h, expected 1000", dut_digits);
        end
        n = 0;
        while (m_total != 5999 && n < 30000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            n_cmp++;
            if (dut_digits !== exp_digits() || rollover !== m_roll) begin
                n_fail++;
                $display("FAIL wrap_track: got %h roll=%b, expected %h roll=%b", dut_digits, rollover, exp_digits(), m_roll);
            end
        end
        n_cmp++;
        if (dut_digits !== 16'h9599) begin
            n_fail++;
            $display("FAIL wrap_9599: got %h, expected 9599", dut_digits);
        end
        repeat (TD) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_digits !== 16'h0000 || rollover !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge: got %h roll=%b run=%b, expected 0000 roll=1 run=1", dut_digits, rollover, running);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (rollover !== 1'b0 || dut_digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_pulse_width: got roll=%b digits=%h, expected roll=0 digits=0000", rollover, dut_digits);
        end
    endtask

    task automatic test_clear_priority();
        int n;
        n = 0;
        while (m_total != 2074 && n < 30000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        n_cmp++;
        if (dut_digits !== 16'h3274) begin
            n_fail++;
            $display("FAIL clear_pre: got %h, expected 3274", dut_digits);
        end
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (dut_digits !== 16'h0000 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_win: got %h run=%b, expected 0000 run=0", dut_digits, running);
        end
        for (int i = 0; i < 2 * TD; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_digits !== 16'h0000 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_hold%0d: got %h run=%b, expected 0000 run=0", i, dut_digits, running);
            end
        end
    endtask

    task automatic test_pause_phase();
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b0 || dut_digits !== 16'h0001) begin
            n_fail++;
            $display("FAIL pause_enter: got %h run=%b, expected 0001 run=0", dut_digits, running);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_digits !== 16'h0001) begin
                n_fail++;
                $display("FAIL pause_hold%0d: got %h, expected 0001", i, dut_digits);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1 || dut_digits !== 16'h0001) begin
            n_fail++;
            $display("FAIL resume: got %h run=%b, expected 0001 run=1", dut_digits, running);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_digits !== 16'h0001) begin
            n_fail++;
            $display("FAIL resume_r1: got %h, expected 0001", dut_digits);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_digits !== 16'h0002) begin
            n_fail++;
            $display("FAIL resume_r2: got %h, expected 0002", dut_digits);
        end
    endtask

    task automatic test_async_reset();
        int n;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_total != 3123 && n < 30000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        n_cmp++;
        if (dut_digits !== 16'h5123) begin
            n_fail++;
            $display("FAIL areset_pre: got %h, expected 5123", dut_digits);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_digits !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async: got %h run=%b roll=%b, expected 0000 0 0", dut_digits, running, rollover);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * TD; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_digits !== 16'h0000 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_stay%0d: got %h run=%b, expected 0000 run=0", i, dut_digits, running);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_restart: got run=%b, expected 1", running);
        end
    endtask

    task automatic test_lap_ignored();
        for (int i = 0; i < 3 * TD; i++) begin
            step(1'b0, 1'b0, (i % 5) == 0);
            n_cmp++;
            if (dut_digits !== exp_digits()) begin
                n_fail++;
                $display("FAIL lap_ignored%0d: got %h, expected %h", i, dut_digits, exp_digits());
            end
        end
    endtask

    task automatic test_random();
        bit ss, clr, lp;
        for (int i = 0; i < 3000; i++) begin
            ss  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 63) == 0);
            lp  = ($urandom_range(0, 15) == 0);
            step(ss, clr, lp);
            n_cmp++;
            if (dut_digits !== exp_digits() || running !== exp_running() || rollover !== m_roll) begin
                n_fail++;
                $display("FAIL random%0d: got %h run=%b roll=%b, expected %h run=%b roll=%b",
                         i, dut_digits, running, rollover, exp_digits(), exp_running(), m_roll);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_carry();
        test_clear_priority();
        test_pause_phase();
        test_async_reset();
        test_lap_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Stopwatch time base and BCD digit counter for the lab stopwatch display path. It divides `clk` down to a tenth-of-a-second tick and counts elapsed time as four BCD digits (M:SS.t, 0:00.0 to 9:59.9) under start/stop and clear control. It sits directly upstream of the seven-segment BCD decoder and drives its `Minutes`, `Tens_Seconds`, `Ones_Seconds` and `Tenths_Seconds` inputs.

## Interface
- `TICK_DIV`, default 10_000_000: `clk` cycles per tenth of a second (100 MHz board clock). Legal range ≥ 2. The bench uses 4.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start_stop`  in  1  single-cycle pulse that toggles run/pause. Already synchronized and debounced upstream.
- `clear`  in  1  single-cycle pulse that zeroes the time and stops the count.
- `lap`  in  1  single-cycle pulse that toggles display freeze. Used only with `LAP_EN`.
- `Minutes`  out  4  BCD 0–9, registered.
- `Tens_Seconds`  out  4  BCD 0–5, registered.
- `Ones_Seconds`  out  4  BCD 0–9, registered.
- `Tenths_Seconds`  out  4  BCD 0–9, registered.
- `running`  out  1  high while in RUN.
- `rollover`  out  1  one-cycle pulse on the wrap from 9:59.9 to 0:00.0.

## Operation
- States:
  - IDLE: cleared and stopped.
  - RUN: counting.
  - PAUSED: stopped with a nonzero or held time.
- Transitions:
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → PAUSED.
  - PAUSED + `start_stop` → RUN.
  - `clear` in any state → IDLE, which zeroes the digits and the prescaler.
- Simultaneous `clear` and `start_stop`: `clear` wins, and the block lands in IDLE.
- Prescaler:
  - Range 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - Advances only in RUN.
  - Holds its value in PAUSED, so a resume continues the partial tenth.
- Tick: RUN with prescaler == TICK_DIV-1. On a tick the prescaler goes to 0 and the digit chain increments once.
- Digit chain, with carries rippling in the same cycle:
  - Tenths 9→0 carries into Ones.
  - Ones 9→0 carries into Tens.
  - Tens 5→0 carries into Minutes.
  - Minutes 9→0 is the full wrap.
- Full wrap (9:59.9 + tick):
  - All digits go to 0.
  - `rollover` is 1 for exactly that one cycle.
  - State stays RUN.
- The digits can never hold a non-BCD value. Tens_Seconds never exceeds 5.
- `start_stop` in RUN on the same edge as a tick: the tick is applied, then the block pauses.
- `lap` without `LAP_EN`: ignored.

## Timing
- Reset values:
  - All four digit outputs: 0.
  - `running`: 0.
  - `rollover`: 0.
  - State: IDLE; prescaler 0; freeze 0.
- Reset asserted mid-count: outputs go to the reset values immediately and asynchronously. Counting resumes only after a new `start_stop` following deassertion.
- `start_stop` sampled in IDLE at edge E:
  - `running` = 1 after edge E.
  - Tenths_Seconds = 1 after edge E+TICK_DIV.
- In RUN, the digits change exactly once every TICK_DIV cycles. The new value is visible after the tick edge, with no extra pipeline stage.
- `clear` at edge E: the digits read 0 and `running` = 0 after edge E.
- Pause/resume preserves phase. A tenth interrupted after k cycles completes TICK_DIV−k cycles after resume.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - A `lap` pulse sets freeze, and the digit outputs hold a snapshot of the count at that edge.
  - The internal count keeps running underneath.
  - The next `lap` pulse clears freeze, and the outputs show the live count from the next cycle.
  - `clear` also clears freeze.
  - `rollover` and `running` are always live.
- Undefined: the `lap` port exists but is ignored, and the digit outputs always track the internal count.

## Test plan
- Reset then run: TICK_DIV=4, deassert `rst_n`, pulse `start_stop` at edge E → `running`=1, Tenths=1 at E+4, Tenths=9 at E+36, digits 0:01.0 at E+40.
- Carry chain: run to 0:59.9 → next tick gives 1:00.0. Run to 9:59.9 → next tick gives 0:00.0 with `rollover` high for exactly one cycle and `running` still 1.
- Pause/resume phase: pulse `start_stop` 2 cycles into a tenth, wait 20 cycles (digits frozen), pulse again → next increment occurs 2 cycles after resume.
- Clear priority: drive `clear` and `start_stop` on the same edge while in RUN at 3:27.4 → 0:00.0, `running`=0, no tick follows.
- Async reset mid-count: assert `rst_n`=0 between edges at 5:12.3 → outputs 0 before the next edge, and they stay 0 after release until `start_stop`.
- Lap (with `STOPWATCH_LAP_EN`): pulse `lap` at 0:02.5, wait 10 ticks → outputs still 0:02.5. Pulse `lap` again → outputs show 0:03.5.
